// File: rtl/mc_ctrl.sv
// Multicycle control FSM for the MIPS-subset datapath: sequences fetch/decode/execute/
// memory/writeback and decodes the datapath controls combinationally from state and IR fields.
module mc_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             OF,
  output logic             PCWr,
  output logic             IRWr,
  output logic             RegWr,
  output logic             MemWr,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             ExtOp,
  output logic [1:0]       NPCop,
  output logic [2:0]       ALUctr,
  output logic             ov_flag,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DCD = 4'd1, S_EXE = 4'd2, S_MA = 4'd3, S_MR = 4'd4,
    S_MW = 4'd5, S_WB = 4'd6, S_BR = 4'd7, S_JMP = 4'd8
  } state_t;

  state_t cur, nxt;
  logic   is_r, pc_wr, ir_wr, reg_wr, mem_wr, retire;

  assign is_r  = (op == OP_R) && (funct == FN_ADDU || funct == FN_SUBU || funct == FN_SLT);
  assign state = cur;

  // Enables are forced low while reset is held, since FETCH itself asserts PCWr/IRWr.
  assign PCWr  = rst_n & pc_wr;
  assign IRWr  = rst_n & ir_wr;
  assign RegWr = rst_n & reg_wr;
  assign MemWr = rst_n & mem_wr;

  always_comb begin
    nxt      = S_FETCH;
    pc_wr    = 1'b0;
    ir_wr    = 1'b0;
    reg_wr   = 1'b0;
    mem_wr   = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ExtOp    = 1'b0;
    NPCop    = 2'b00;
    ALUctr   = 3'b000;
    case (cur)
      S_FETCH: begin
        pc_wr   = 1'b1;
        ir_wr   = 1'b1;
        ALUSrcB = 2'b01;
        nxt     = S_DCD;
      end
      S_DCD: begin
        ALUSrcB = 2'b11;
        ExtOp   = 1'b1;
        if (is_r || op == OP_ORI || op == OP_LUI || op == OP_ADDI) nxt = S_EXE;
        else if (op == OP_LW || op == OP_SW)                        nxt = S_MA;
        else if (op == OP_BEQ)                                      nxt = S_BR;
        else if (op == OP_J)                                        nxt = S_JMP;
        else                                                        nxt = S_FETCH;
      end
      S_EXE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = is_r ? 2'b00 : 2'b10;
        ExtOp   = (op == OP_ADDI);
        if (is_r) begin
          case (funct)
            FN_SUBU: ALUctr = 3'b001;
            FN_SLT:  ALUctr = 3'b100;
            default: ALUctr = 3'b000;
          endcase
        end else begin
          case (op)
            OP_ORI:  ALUctr = 3'b010;
            OP_LUI:  ALUctr = 3'b011;
            default: ALUctr = 3'b000;
          endcase
        end
        nxt = S_WB;
      end
      S_MA: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ExtOp   = 1'b1;
        nxt     = (op == OP_LW) ? S_MR : S_MW;
      end
      S_MR: nxt = S_WB;
      S_MW: mem_wr = 1'b1;
      // Only lw reaches WB through MR, so op identifies the memory-data writeback.
      S_WB: begin
        RegDst   = is_r;
        MemtoReg = (op == OP_LW);
        reg_wr   = !((op == OP_ADDI) && ov_flag);
      end
      S_BR: begin
        ALUSrcA = 1'b1;
        ALUctr  = 3'b001;
        NPCop   = 2'b01;
        pc_wr   = zero;
      end
      S_JMP: begin
        pc_wr = 1'b1;
        NPCop = 2'b10;
      end
      default: nxt = S_FETCH;
    endcase
  end

  assign retire = (cur == S_WB) || (cur == S_MW) || (cur == S_BR) || (cur == S_JMP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur       <= S_FETCH;
      ov_flag   <= 1'b0;
      instr_cnt <= '0;
    end else begin
      cur <= nxt;
      if (cur == S_EXE && op == OP_ADDI) ov_flag <= OF;
      if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks each instruction class through its state sequence
// and checks hand-derived control values, counter and sticky overflow.
module tb_mc_ctrl;
  localparam int unsigned CNT_W = 32;

  logic             clk, rst_n, zero, OF;
  logic [5:0]       op, funct;
  logic             PCWr, IRWr, RegWr, MemWr, RegDst, MemtoReg, ALUSrcA, ExtOp, ov_flag;
  logic [1:0]       ALUSrcB, NPCop;
  logic [2:0]       ALUctr;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  mc_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .OF(OF),
    .PCWr(PCWr), .IRWr(IRWr), .RegWr(RegWr), .MemWr(MemWr), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtOp(ExtOp),
    .NPCop(NPCop), .ALUctr(ALUctr), .ov_flag(ov_flag), .state(state), .instr_cnt(instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample mid-low-phase; check the state reached.
  task automatic step(input logic [3:0] exp_state);
    @(negedge clk);
    #1;
    check("state", 32'(state), 32'(exp_state));
  endtask

  task automatic issue(input logic [5:0] o, input logic [5:0] f);
    op    = o;
    funct = f;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; op = '0; funct = '0; zero = 1'b0; OF = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_pcwr", 32'(PCWr), 32'd0);
    check("rst_irwr", 32'(IRWr), 32'd0);
    check("rst_cnt", instr_cnt, 32'd0);
    check("rst_ov", 32'(ov_flag), 32'd0);

    // addu
    rst_n = 1'b1;
    issue(6'b000000, 6'b100001);
    check("fetch_pcwr", 32'(PCWr), 32'd1);
    check("fetch_irwr", 32'(IRWr), 32'd1);
    check("fetch_srcb", 32'(ALUSrcB), 32'd1);
    step(4'd1);
    check("dcd_srcb", 32'(ALUSrcB), 32'd3);
    check("dcd_ext", 32'(ExtOp), 32'd1);
    check("dcd_pcwr", 32'(PCWr), 32'd0);
    step(4'd2);
    check("addu_ctr", 32'(ALUctr), 32'd0);
    check("addu_srca", 32'(ALUSrcA), 32'd1);
    check("addu_srcb", 32'(ALUSrcB), 32'd0);
    check("addu_exe_regwr", 32'(RegWr), 32'd0);
    step(4'd6);
    check("addu_regwr", 32'(RegWr), 32'd1);
    check("addu_regdst", 32'(RegDst), 32'd1);
    check("addu_m2r", 32'(MemtoReg), 32'd0);
    step(4'd0);
    check("cnt_addu", instr_cnt, 32'd1);

    // subu and slt ALU codes
    issue(6'b000000, 6'b100011);
    step(4'd1); step(4'd2);
    check("subu_ctr", 32'(ALUctr), 32'd1);
    step(4'd6); step(4'd0);
    issue(6'b000000, 6'b101010);
    step(4'd1); step(4'd2);
    check("slt_ctr", 32'(ALUctr), 32'd4);
    step(4'd6); step(4'd0);
    check("cnt_rtype", instr_cnt, 32'd3);

    // lw
    issue(6'b100011, 6'b000000);
    step(4'd1); step(4'd3);
    check("lw_ma_srcb", 32'(ALUSrcB), 32'd2);
    check("lw_ma_ext", 32'(ExtOp), 32'd1);
    step(4'd4);
    check("lw_mr_regwr", 32'(RegWr), 32'd0);
    check("lw_mr_memwr", 32'(MemWr), 32'd0);
    step(4'd6);
    check("lw_m2r", 32'(MemtoReg), 32'd1);
    check("lw_regdst", 32'(RegDst), 32'd0);
    check("lw_regwr", 32'(RegWr), 32'd1);
    step(4'd0);
    check("cnt_lw", instr_cnt, 32'd4);

    // sw
    issue(6'b101011, 6'b000000);
    step(4'd1);
    check("sw_dcd_memwr", 32'(MemWr), 32'd0);
    step(4'd3); step(4'd5);
    check("sw_memwr", 32'(MemWr), 32'd1);
    check("sw_regwr", 32'(RegWr), 32'd0);
    step(4'd0);
    check("sw_fetch_memwr", 32'(MemWr), 32'd0);
    check("cnt_sw", instr_cnt, 32'd5);

    // beq taken / not taken
    issue(6'b000100, 6'b000000);
    zero = 1'b1;
    step(4'd1); step(4'd7);
    check("beq_t_pcwr", 32'(PCWr), 32'd1);
    check("beq_npc", 32'(NPCop), 32'd1);
    check("beq_ctr", 32'(ALUctr), 32'd1);
    step(4'd0);
    zero = 1'b0;
    step(4'd1); step(4'd7);
    check("beq_nt_pcwr", 32'(PCWr), 32'd0);
    step(4'd0);
    check("cnt_beq", instr_cnt, 32'd7);

    // addi overflow then clean
    issue(6'b001000, 6'b000000);
    step(4'd1); step(4'd2);
    check("addi_ext", 32'(ExtOp), 32'd1);
    check("addi_srcb", 32'(ALUSrcB), 32'd2);
    OF = 1'b1;
    step(4'd6);
    OF = 1'b0;
    check("addi_ov_set", 32'(ov_flag), 32'd1);
    check("addi_ov_regwr", 32'(RegWr), 32'd0);
    step(4'd0);
    step(4'd1); step(4'd2); step(4'd6);
    check("addi_ov_clr", 32'(ov_flag), 32'd0);
    check("addi_regwr", 32'(RegWr), 32'd1);
    step(4'd0);

    // ori / lui
    issue(6'b001101, 6'b000000);
    step(4'd1); step(4'd2);
    check("ori_ctr", 32'(ALUctr), 32'd2);
    check("ori_ext", 32'(ExtOp), 32'd0);
    step(4'd6);
    check("ori_regdst", 32'(RegDst), 32'd0);
    step(4'd0);
    issue(6'b001111, 6'b000000);
    step(4'd1); step(4'd2);
    check("lui_ctr", 32'(ALUctr), 32'd3);
    step(4'd6); step(4'd0);
    check("cnt_imm", instr_cnt, 32'd11);

    // unsupported op, then bad R funct
    issue(6'b111111, 6'b000000);
    step(4'd1);
    check("bad_regwr", 32'(RegWr), 32'd0);
    step(4'd0);
    issue(6'b000000, 6'b111111);
    step(4'd1); step(4'd0);
    check("cnt_bad", instr_cnt, 32'd11);

    // j
    issue(6'b000010, 6'b000000);
    step(4'd1); step(4'd8);
    check("j_pcwr", 32'(PCWr), 32'd1);
    check("j_npc", 32'(NPCop), 32'd2);
    step(4'd0);
    check("cnt_j", instr_cnt, 32'd12);

    // set ov_flag, then reset in MW of sw
    issue(6'b001000, 6'b000000);
    OF = 1'b1;
    step(4'd1); step(4'd2); step(4'd6); step(4'd0);
    OF = 1'b0;
    check("ov_before_rst", 32'(ov_flag), 32'd1);
    issue(6'b101011, 6'b000000);
    step(4'd1); step(4'd3); step(4'd5);
    check("mw_memwr", 32'(MemWr), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_memwr", 32'(MemWr), 32'd0);
    check("rst_mid_state", 32'(state), 32'd0);
    check("rst_mid_cnt", instr_cnt, 32'd0);
    check("rst_mid_ov", 32'(ov_flag), 32'd0);
    check("rst_mid_pcwr", 32'(PCWr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_state", 32'(state), 32'd0);
    step(4'd1);
    check("post_rst_cnt", instr_cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
